// File: rtl/lsu_pkg.sv
// Shared definitions for the RV64I load/store unit.
//   XLEN        : data / address width (fixed at 64)
//   F3_*        : RV64I funct3 size/sign codes for loads and stores
//   lsu_state_t : FSM state encoding
//   size_byte_mask : byte-enable pattern (at lane 0) for an access size
package lsu_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } lsu_state_t;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic for the load/store unit.
//   i_word       : doubleword read from memory
//   i_store_data : store operand (low bytes used for partial stores)
//   i_offset     : byte offset within the doubleword (addr[2:0])
//   i_funct3     : RV64I size/sign code
//   o_load_data  : extracted and sign/zero-extended load result
//   o_merged     : i_word with the addressed bytes replaced by store data
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [2:0]      i_offset,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_load_data,
    output logic [XLEN-1:0] o_merged
);

    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;
    logic [7:0]      w_byte_en;
    logic [XLEN-1:0] w_bit_mask;

    assign w_shamt   = {i_offset, 3'b000};
    assign w_shifted = i_word >> w_shamt;

    always_comb begin
        o_load_data = w_shifted;
        case (i_funct3)
            F3_B:    o_load_data = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            F3_H:    o_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_load_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            F3_BU:   o_load_data = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            F3_HU:   o_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            F3_WU:   o_load_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default: o_load_data = w_shifted;
        endcase
    end

    // Accesses are already alignment-checked, so the shifted enables never wrap.
    assign w_byte_en = size_byte_mask(i_funct3[1:0]) << i_offset;

    always_comb begin
        w_bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_bit_mask[i*8 +: 8] = {8{w_byte_en[i]}};
        end
    end

    assign o_merged = (i_word & ~w_bit_mask) | ((i_store_data << w_shamt) & w_bit_mask);

endmodule

// File: rtl/load_store_unit.sv
// RV64I load/store unit: turns byte-addressed load/store requests into
// doubleword accesses on data_memory, with alignment/range checking,
// load extension and read-modify-write for partial stores.
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   start, is_load, is_store, funct3, addr, store_data : request from execute
//   busy, done            : handshake (done is a one-cycle pulse)
//   load_data             : extended load result, held until the next load
//   misaligned, access_fault : fault flags, valid with done
//   mem_address, memread, memwrite, mem_write_data, mem_read_data : data_memory
module load_store_unit #(
    parameter int ADDR_BITS = 10,
    parameter int XLEN      = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic [2:0]           funct3,
    input  logic [XLEN-1:0]      addr,
    input  logic [XLEN-1:0]      store_data,
    output logic                 busy,
    output logic                 done,
    output logic [XLEN-1:0]      load_data,
    output logic                 misaligned,
    output logic                 access_fault,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 memread,
    output logic                 memwrite,
    output logic [XLEN-1:0]      mem_write_data,
    input  logic [XLEN-1:0]      mem_read_data
);

    import lsu_pkg::*;

    lsu_state_t            r_state;
    logic [ADDR_BITS+2:0]  r_addr;
    logic [2:0]            r_funct3;
    logic [XLEN-1:0]       r_store_data;
    logic                  r_is_load;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_memread;
    logic                  r_memwrite;
    logic [XLEN-1:0]       r_write_data;
    logic [XLEN-1:0]       r_load_data;
    logic                  r_misaligned;
    logic                  r_access_fault;

    logic                  w_bad_op;
    logic                  w_bad_funct3;
    logic                  w_bad_range;
    logic                  w_access_fault;
    logic                  w_misaligned;
    logic [XLEN-1:0]       w_lane_load;
    logic [XLEN-1:0]       w_lane_merged;

    // Faults are classified as the request is latched so that a faulting
    // request reaches DONE one cycle after start without touching memory.
    assign w_bad_op       = (is_load == is_store);
    assign w_bad_funct3   = is_load ? (funct3 == 3'b111) : (funct3 > F3_D);
    assign w_bad_range    = |addr[XLEN-1:ADDR_BITS+3];
    assign w_access_fault = w_bad_op | w_bad_funct3 | w_bad_range;

    always_comb begin
        case (funct3[1:0])
            2'b01:   w_misaligned = addr[0];
            2'b10:   w_misaligned = |addr[1:0];
            2'b11:   w_misaligned = |addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    lsu_byte_lane u_byte_lane (
        .i_word       (mem_read_data),
        .i_store_data (r_store_data),
        .i_offset     (r_addr[2:0]),
        .i_funct3     (r_funct3),
        .o_load_data  (w_lane_load),
        .o_merged     (w_lane_merged)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_addr         <= '0;
            r_funct3       <= '0;
            r_store_data   <= '0;
            r_is_load      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_memread      <= 1'b0;
            r_memwrite     <= 1'b0;
            r_write_data   <= '0;
            r_load_data    <= '0;
            r_misaligned   <= 1'b0;
            r_access_fault <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr         <= addr[ADDR_BITS+2:0];
                        r_funct3       <= funct3;
                        r_store_data   <= store_data;
                        r_is_load      <= is_load;
                        r_busy         <= 1'b1;
                        r_access_fault <= w_access_fault;
                        r_misaligned   <= w_misaligned & ~w_access_fault;
                        if (w_access_fault || w_misaligned) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (is_load || (funct3[1:0] != 2'b11)) begin
                            // Loads and partial stores both need the old doubleword.
                            r_state   <= ST_READ;
                            r_memread <= 1'b1;
                        end else begin
                            r_state      <= ST_WRITE;
                            r_memwrite   <= 1'b1;
                            r_write_data <= store_data;
                        end
                    end
                end
                ST_READ: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_memread <= 1'b0;
                    if (r_is_load) begin
                        r_load_data <= w_lane_load;
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                    end else begin
                        r_write_data <= w_lane_merged;
                        r_memwrite   <= 1'b1;
                        r_state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_memwrite <= 1'b0;
                    r_state    <= ST_DONE;
                    r_done     <= 1'b1;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy     <= 1'b0;
                    r_memread  <= 1'b0;
                    r_memwrite <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign load_data      = r_load_data;
    assign misaligned     = r_misaligned;
    assign access_fault   = r_access_fault;
    assign mem_address    = r_addr[ADDR_BITS+2:3];
    assign memread        = r_memread;
    assign memwrite       = r_memwrite;
    assign mem_write_data = r_write_data;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the execute stage and data_memory and converts RV64I load/store requests into doubleword-granular memory accesses. Handles LB/LH/LW/LD/LBU/LHU/LWU and SB/SH/SW/SD, including:
- alignment checking
- sign/zero extension of load results
- read-modify-write merging for partial stores

Uses a multi-cycle FSM with a start/busy/done handshake to the core.

Parameters:
- ADDR_BITS, 10, width of data_memory doubleword index (memory holds 2^ADDR_BITS 64-bit entries).
- XLEN, 64, data and address width; fixed at 64, other values unsupported.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- is_load  input  1  request is a load.
- is_store  input  1  request is a store.
- funct3  input  3  RV64I size/sign code.
- addr  input  64  byte address.
- store_data  input  64  store operand; low bytes used for partial stores.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- load_data  output  64  extended load result; valid from done, held until next done.
- misaligned  output  1  valid with done; alignment fault, no memory access performed.
- access_fault  output  1  valid with done; bad funct3, bad opcode combination, or out-of-range address.
- mem_address  output  ADDR_BITS  to data_memory: addr[ADDR_BITS+2:3].
- memread  output  1  to data_memory.
- memwrite  output  1  to data_memory.
- mem_write_data  output  64  to data_memory.
- mem_read_data  input  64  from data_memory; valid the cycle after memread first asserted.

Behaviour:
- Reset values: all outputs 0; state IDLE; load_data 0. Reset is asynchronous, so memread/memwrite drop immediately, including mid-operation; no partial write completes after reset is asserted.
- States: IDLE, READ, CAPTURE, WRITE, DONE.
- Request latch (in IDLE when start=1):
  - addr, funct3, store_data and op are registered.
  - mem_address is driven from the latched addr and held stable until DONE.
- Error detection, checked on the latched request; any error goes IDLE->DONE with the flag set and no memread/memwrite:
  - access_fault: is_load==is_store; load funct3==3'b111; store funct3>3'b011; addr[63:ADDR_BITS+3] nonzero.
  - misaligned: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0.
  - Fault priority: access_fault over misaligned.
- Load: IDLE->READ (memread=1) -> CAPTURE (memread=1, sample mem_read_data) -> DONE.
  - Extraction: byte lane = addr[2:0], LSB-first (byte 0 = bits 7:0).
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend; LD passes through.
  - Latency: done 3 cycles after start.
- Store SD: IDLE->WRITE (memwrite=1, mem_write_data=store_data) -> DONE. done 2 cycles after start.
- Partial store (SB/SH/SW): IDLE->READ->CAPTURE (sample old word) -> WRITE (merged word) -> DONE.
  - Merge: replace only the addressed bytes with store_data low bytes; all other bytes are preserved.
  - done 4 cycles after start.
- Strobe exclusivity: memread and memwrite are never high in the same cycle.
- DONE: done=1 for exactly one cycle, then IDLE. Flags are cleared on the next accepted start.
- Handshake: start while busy is ignored (not queued). start in the cycle DONE->IDLE is likewise ignored; the earliest accepted start is the cycle after done.
- load_data updates only on successful loads; stores and faults leave it unchanged.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - state encoding.
  - XLEN.
- One combinational sub-module, lsu_byte_lane, contains the lane logic:
  - load extraction/extension: (word, offset, funct3) -> result.
  - store merge: (old word, store_data, offset, funct3) -> new word.

Test Plan:
- SD 0xAAAAAAAAAAAAAAAA at addr 400: mem_address=50, memwrite high exactly 1 cycle, memread never high, done at start+2.
- SB 0x5A at addr 403 over that word: READ/CAPTURE then WRITE with mem_write_data=0xAAAAAAAA5AAAAAAA, done at start+4.
- Loads from the resulting word:
  - LB addr 403 -> load_data=0x000000000000005A.
  - LH addr 400 -> 0xFFFFFFFFFFFFAAAA.
  - LHU addr 400 -> 0x000000000000AAAA.
  - LD addr 400 -> 0xAAAAAAAA5AAAAAAA.
  - Each completes with done at start+3.
- Error cases (done at start+1, no memread/memwrite, load_data unchanged):
  - LW addr 401 -> misaligned=1.
  - SW with addr=0x10000 -> access_fault=1.
  - is_load=is_store=1 -> access_fault=1.
- Reset asserted low during WRITE of an SH: memwrite drops combinationally; after release busy=0, done=0, and the memory word is unchanged.
- start pulsed during busy of an LD: the second request is ignored, exactly one done pulse occurs, and a start the cycle after done is accepted.
